sudoku_result_checker: RTL and testbench

// - Consumes the 81-cell serial solution stream from the SUDOKU solver (out_valid/out, row-major, one
//   4-bit digit per cycle) and checks it in-line. Checks: digits in range, and no repeated digit in any row, column or box.
// - Emits a one-cycle verdict per frame with error flags, plus a saturating pass counter for regression.
// - Sits directly downstream of the solver, in the testbench harness and in the on-chip self-test path.

---
 rtl/sudoku_result_checker.sv | 236 +++++++++++++++++++++++
 tb/tb_sudoku_result_checker.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sudoku_result_checker.sv
// sudoku_result_checker
// ---------------------------------------------------------------------------
// In-line checker for the serial 81-cell SUDOKU solution stream (row-major,
// one 4-bit digit per accepted cell). Each frame gets one verdict strobe
// with error flags. A saturating counter tallies the frames that pass.
//
// Handshake: sol_valid and puz_valid are plain qualifiers. There is no
// ready or backpressure. A cell is taken on every posedge where its valid is
// high and the checker is able to take it. Solution cells that arrive while
// the verdict is being reported are dropped.
//
// Optional feature: define GIVEN_CHECK_EN to build an 81x4 puzzle store.
// Solution cells are then compared against the loaded givens (chk_err[3]).
// Without the macro, puz_valid and puz are unused and chk_err[3] is 0.
//
// Parameters:
//   GAP_MAX     max consecutive idle cycles tolerated mid-frame (0 = contiguous)
//   PASS_CNT_W  width of pass_cnt
// Ports:
//   clk        clock, all logic on posedge
//   rst_n      synchronous active-low reset
//   sol_valid  solution cell valid
//   sol        solution digit
//   puz_valid  puzzle cell valid (GIVEN_CHECK_EN only)
//   puz        puzzle digit, 0 = blank (GIVEN_CHECK_EN only)
//   chk_valid  verdict strobe, one cycle per frame
//   chk_pass   frame legal; 0 whenever chk_valid = 0
//   chk_err    [0] range, [1] duplicate, [2] length/abort, [3] given mismatch
//   pass_cnt   saturating count of passed frames
// ---------------------------------------------------------------------------
module sudoku_result_checker #(
  parameter int GAP_MAX    = 2,
  parameter int PASS_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sol_valid,
  input  logic [3:0]            sol,
  input  logic                  puz_valid,
  input  logic [3:0]            puz,
  output logic                  chk_valid,
  output logic                  chk_pass,
  output logic [3:0]            chk_err,
  output logic [PASS_CNT_W-1:0] pass_cnt
);

  // The gap counter only ever needs to hold values up to GAP_MAX.
  localparam int GAP_W = (GAP_MAX < 1) ? 1 : $clog2(GAP_MAX + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    REPORT  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Cell position counters. Box coordinates are tracked directly, so no
  // divide or modulo is needed.
  logic [6:0] k_q;      // linear cell index 0..80
  logic [3:0] r_q;      // row 0..8
  logic [3:0] c_q;      // column 0..8
  logic [1:0] cin_q;    // column within box 0..2
  logic [1:0] rin_q;    // row within box 0..2
  logic [1:0] bc_q;     // box column 0..2
  logic [1:0] br_q;     // box row 0..2
  logic [GAP_W-1:0] gap_q;

  logic [8:0] row_seen [9];
  logic [8:0] col_seen [9];
  logic [8:0] box_seen [9];
  logic [3:0] err_q;

  logic       accept;
  logic       done;
  logic       abort;
  logic       digit_ok;
  logic [3:0] idx;
  logic [3:0] box_idx;
  logic       seen_hit;
  logic       given_bad;
  logic [3:0] err_d;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sol_valid) begin
          accept  = 1'b1;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (sol_valid) begin
          accept = 1'b1;
          if (k_q == 7'd80) begin
            done    = 1'b1;
            state_d = REPORT;
          end
        end else if (gap_q == GAP_W'(GAP_MAX)) begin
          // This idle cycle would be GAP_MAX+1 in a row.
          abort   = 1'b1;
          state_d = REPORT;
        end
      end
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------- cell check
  always_comb begin
    digit_ok = (sol >= 4'd1) && (sol <= 4'd9);
    idx      = sol - 4'd1;
    box_idx  = 4'(br_q) * 4'd3 + 4'(bc_q);
    seen_hit = 1'b0;
    if (digit_ok)
      seen_hit = row_seen[r_q][idx] | col_seen[c_q][idx] | box_seen[box_idx][idx];
    err_d = err_q | {accept & given_bad, abort, accept & seen_hit, accept & ~digit_ok};
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_q       <= '0;
      r_q       <= '0;
      c_q       <= '0;
      cin_q     <= '0;
      rin_q     <= '0;
      bc_q      <= '0;
      br_q      <= '0;
      gap_q     <= '0;
      err_q     <= '0;
      chk_valid <= 1'b0;
      chk_pass  <= 1'b0;
      chk_err   <= '0;
      pass_cnt  <= '0;
      for (int i = 0; i < 9; i++) begin
        row_seen[i] <= '0;
        col_seen[i] <= '0;
        box_seen[i] <= '0;
      end
    end else begin
      // The verdict is registered on the same edge that ends the frame.
      chk_valid <= done | abort;
      chk_pass  <= done && (err_d == 4'd0);
      chk_err   <= (done | abort) ? err_d : 4'd0;

      if (chk_valid && chk_pass && (pass_cnt != {PASS_CNT_W{1'b1}}))
        pass_cnt <= pass_cnt + 1'b1;

      if (state_q == REPORT) begin
        k_q   <= '0;
        r_q   <= '0;
        c_q   <= '0;
        cin_q <= '0;
        rin_q <= '0;
        bc_q  <= '0;
        br_q  <= '0;
        gap_q <= '0;
        err_q <= '0;
        for (int i = 0; i < 9; i++) begin
          row_seen[i] <= '0;
          col_seen[i] <= '0;
          box_seen[i] <= '0;
        end
      end else begin
        err_q <= err_d;
        if (accept) begin
          gap_q <= '0;
          k_q   <= k_q + 7'd1;
          if (digit_ok) begin
            row_seen[r_q][idx]     <= 1'b1;
            col_seen[c_q][idx]     <= 1'b1;
            box_seen[box_idx][idx] <= 1'b1;
          end
          if (c_q == 4'd8) begin
            c_q   <= '0;
            cin_q <= '0;
            bc_q  <= '0;
            r_q   <= r_q + 4'd1;
            if (rin_q == 2'd2) begin
              rin_q <= '0;
              br_q  <= br_q + 2'd1;
            end else begin
              rin_q <= rin_q + 2'd1;
            end
          end else begin
            c_q <= c_q + 4'd1;
            if (cin_q == 2'd2) begin
              cin_q <= '0;
              bc_q  <= bc_q + 2'd1;
            end else begin
              cin_q <= cin_q + 2'd1;
            end
          end
        end else if ((state_q == COLLECT) && !abort) begin
          gap_q <= gap_q + GAP_W'(1);
        end
      end
    end
  end

  // ------------------------------------------------------- given store
`ifdef GIVEN_CHECK_EN
  logic [3:0] given_q [81];
  logic [6:0] wptr_q;

  always_ff @(posedge clk) begin
    if (!rst_n || (state_q == REPORT)) begin
      wptr_q <= '0;
      for (int i = 0; i < 81; i++) given_q[i] <= '0;
    end else if (puz_valid && (wptr_q < 7'd81)) begin
      given_q[wptr_q] <= puz;
      wptr_q          <= wptr_q + 7'd1;
    end
  end

  // Blank or never-loaded cells read as 0 and are not checked.
  assign given_bad = (given_q[k_q] != 4'd0) && (given_q[k_q] != sol);
`else
  logic unused_puz;
  assign unused_puz = ^{puz_valid, puz};
  assign given_bad  = 1'b0;
`endif

endmodule

// File: tb/tb_sudoku_result_checker.sv
// tb_sudoku_result_checker
// Directed and randomized frames for sudoku_result_checker. Expected
// verdicts come from a grid-level model that checks rows, columns and boxes
// with index arithmetic. A negedge monitor pops them from exp_q.
module tb_sudoku_result_checker;
  localparam int GAP_MAX    = 2;
  localparam int PASS_CNT_W = 16;

  // ---------------------------------------------------- clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                  sol_valid = 1'b0;
  logic [3:0]            sol = '0;
  logic                  puz_valid = 1'b0;
  logic [3:0]            puz = '0;
  logic                  chk_valid;
  logic                  chk_pass;
  logic [3:0]            chk_err;
  logic [PASS_CNT_W-1:0] pass_cnt;

  sudoku_result_checker #(.GAP_MAX(GAP_MAX), .PASS_CNT_W(PASS_CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sol_valid (sol_valid),
    .sol       (sol),
    .puz_valid (puz_valid),
    .puz       (puz),
    .chk_valid (chk_valid),
    .chk_pass  (chk_pass),
    .chk_err   (chk_err),
    .pass_cnt  (pass_cnt)
  );

  int checks = 0;
  int errors = 0;
  int verdicts = 0;
  int exp_pass_cnt = 0;
  logic [4:0] exp_q[$];     // {pass, err[3:0]}
  int grid[81];
  int sol_a[81];
  int puz_a[81];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ------------------------------------------------------ reference model
  function automatic logic [4:0] model_verdict(input int n);
    logic [3:0] e;
    e = 4'd0;
    for (int k = 0; k < n; k++) begin
      int v;
      v = sol_a[k];
      if (v < 1 || v > 9) e[0] = 1'b1;
      else begin
        for (int j = 0; j < k; j++) begin
          if (sol_a[j] == v &&
              (j / 9 == k / 9 || j % 9 == k % 9 ||
               (j / 27 == k / 27 && (j % 9) / 3 == (k % 9) / 3)))
            e[1] = 1'b1;
        end
      end
`ifdef GIVEN_CHECK_EN
      if (puz_a[k] != 0 && puz_a[k] != v) e[3] = 1'b1;
`endif
    end
    if (n < 81) e[2] = 1'b1;
    return {(n == 81 && e == 4'd0), e};
  endfunction

  // Random legal grid: shifted-band pattern with a digit permutation.
  task automatic make_grid();
    int p[9];
    int s;
    for (int i = 0; i < 9; i++) p[i] = i + 1;
    for (int i = 8; i > 0; i--) begin
      int j, t;
      j = $urandom_range(i, 0);
      t = p[i]; p[i] = p[j]; p[j] = t;
    end
    s = $urandom_range(8, 0);
    for (int k = 0; k < 81; k++) begin
      int r, c;
      r = k / 9;
      c = k % 9;
      grid[k] = p[((r % 3) * 3 + r / 3 + c + s) % 9];
    end
    for (int k = 0; k < 81; k++) sol_a[k] = grid[k];
  endtask

  // ------------------------------------------------------------ drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cell(input int v);
    sol_valid = 1'b1;
    sol = 4'(v);
    tick();
    sol_valid = 1'b0;
  endtask

  task automatic load_puzzle();
    for (int k = 0; k < 81; k++) begin
      puz_valid = 1'b1;
      puz = 4'(puz_a[k]);
      tick();
    end
    puz_valid = 1'b0;
  endtask

  task automatic send_frame(input int n, input int max_gap, input string tag);
    logic [4:0] e;
    e = model_verdict(n);
    exp_q.push_back(e);
    for (int k = 0; k < n; k++) begin
      if (k > 0 && max_gap > 0 && $urandom_range(3, 0) == 0)
        repeat ($urandom_range(max_gap, 1)) tick();
      if (k == 80) check({tag, "_no_early"}, chk_valid, 0);
      drive_cell(sol_a[k]);
    end
    if (n == 81) begin
      check({tag, "_latency"}, chk_valid, 1);
    end else begin
      repeat (GAP_MAX) begin
        check({tag, "_gap_hold"}, chk_valid, 0);
        tick();
      end
      check({tag, "_gap_hold"}, chk_valid, 0);
      tick();
      check({tag, "_abort_latency"}, chk_valid, 1);
    end
    if (e[4] && exp_pass_cnt < (1 << PASS_CNT_W) - 1) exp_pass_cnt++;
    tick();
    check({tag, "_after_valid"}, chk_valid, 0);
    check({tag, "_after_pass"}, chk_pass, 0);
    check({tag, "_after_err"}, chk_err, 0);
    check({tag, "_pass_cnt"}, pass_cnt, exp_pass_cnt);
    for (int k = 0; k < 81; k++) puz_a[k] = 0;
  endtask

  // --------------------------------------------------------- scoreboard
  always @(negedge clk) begin : monitor
    logic [4:0] e;
    if (rst_n && chk_valid) begin
      verdicts++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL verdict_unexpected: observed=chk_valid 1 expected=no verdict");
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("verdict_pass", chk_pass, e[4]);
        check("verdict_err", chk_err, e[3:0]);
      end
    end
  end

  // ------------------------------------------------------------ stimulus
  initial begin
    for (int k = 0; k < 81; k++) puz_a[k] = 0;

    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_valid", chk_valid, 0);
    check("reset_pass", chk_pass, 0);
    check("reset_err", chk_err, 0);
    check("reset_pass_cnt", pass_cnt, 0);
    rst_n = 1'b1;
    tick();

    // Legal contiguous frame.
    make_grid();
    send_frame(81, 0, "legal");

    // Cell 40 replaced by another valid digit.
    sol_a[40] = (grid[40] % 9) + 1;
    send_frame(81, 0, "dup40");

    // Out-of-range digits in cells 0 and 1.
    for (int k = 0; k < 81; k++) sol_a[k] = grid[k];
    sol_a[0] = 0;
    sol_a[1] = 12;
    send_frame(81, 0, "range");

    // Stream stops after 50 cells.
    make_grid();
    send_frame(50, 0, "gap_abort");

    // Reset at cell 30, then one full legal frame.
    make_grid();
    for (int k = 0; k < 30; k++) drive_cell(grid[k]);
    rst_n = 1'b0;
    sol_valid = 1'b1;
    sol = 4'(grid[30]);
    tick();
    rst_n = 1'b1;
    sol_valid = 1'b0;
    exp_pass_cnt = 0;
    check("midreset_valid", chk_valid, 0);
    check("midreset_pass_cnt", pass_cnt, 0);
    tick();
    begin
      int v0;
      v0 = verdicts;
      send_frame(81, 0, "post_reset");
      check("post_reset_one_verdict", verdicts - v0, 1);
    end

    // Given mismatch at cell 2 on an otherwise legal solution.
    make_grid();
    for (int k = 0; k < 81; k++) puz_a[k] = ($urandom_range(1, 0) == 1) ? grid[k] : 0;
    puz_a[2] = (grid[2] % 9) + 1;
    load_puzzle();
    send_frame(81, 0, "given");

    // Randomized frames: gaps, corruptions, givens and short frames.
    for (int f = 0; f < 10; f++) begin
      int mode;
      int n;
      make_grid();
      mode = $urandom_range(3, 0);
      n = 81;
      if (mode == 1) sol_a[$urandom_range(80, 0)] = $urandom_range(15, 0);
      if (mode == 2) begin
        for (int k = 0; k < 81; k++)
          puz_a[k] = ($urandom_range(2, 0) == 0) ? grid[k] : 0;
        if ($urandom_range(1, 0) == 1) puz_a[$urandom_range(80, 0)] = $urandom_range(9, 1);
        load_puzzle();
      end
      if (mode == 3) n = $urandom_range(80, 1);
      send_frame(n, GAP_MAX, "rand");
    end

    repeat (2) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
